// File: rtl/intercal_alu_sched.sv
// Round-robin scheduler sharing one external INTERCAL ALU between two requesters; INTERCAL_SCHED_CHAIN_EN feeds a requester's last result back as operand A.
// Latency: accept at edge N, rsp_valid from edge N+EXEC_CYCLES; one op per EXEC_CYCLES+2 cycles.
// Backpressure: cmd_ready only in IDLE; RESP holds result until the owner's rsp_ready.
module intercal_alu_sched #(
    parameter int EXEC_CYCLES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cmd_valid,
    output logic [1:0]       cmd_ready,
    input  logic [7:0]       cmd_op,
    input  logic [63:0]      cmd_a,
    input  logic [63:0]      cmd_b,
    input  logic [1:0]       cmd_chain,
    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [31:0]      rsp_data,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    input  logic [31:0]      alu_f,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(EXEC_CYCLES - 1);

    state_t      state_q, state_d;
    logic        last_grant;
    logic        owner_q;
    logic [3:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [3:0]  cnt_q;

    logic        grant;
    logic        accept;
    logic        rsp_hs;
    logic [3:0]  op_sel;
    logic [31:0] a_raw, a_sel, b_sel;

    // A tie goes to whoever did not win last time.
    always_comb begin
        grant = cmd_valid[1];
        if (cmd_valid == 2'b11) begin
            grant = ~last_grant;
        end
    end

    assign accept = (state_q == IDLE) && (|cmd_valid) && !rst;
    assign rsp_hs = (state_q == RESP) && rsp_ready[owner_q];

    assign op_sel = grant ? cmd_op[7:4]  : cmd_op[3:0];
    assign a_raw  = grant ? cmd_a[63:32] : cmd_a[31:0];
    assign b_sel  = grant ? cmd_b[63:32] : cmd_b[31:0];

`ifdef INTERCAL_SCHED_CHAIN_EN
    logic [31:0] last_result_0, last_result_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            last_result_0 <= '0;
            last_result_1 <= '0;
        end else if (rsp_hs) begin
            if (owner_q) begin
                last_result_1 <= rsp_data;
            end else begin
                last_result_0 <= rsp_data;
            end
        end
    end

    assign a_sel = (grant ? cmd_chain[1] : cmd_chain[0]) ?
                   (grant ? last_result_1 : last_result_0) : a_raw;
`else
    logic unused_chain;
    assign unused_chain = ^cmd_chain;
    assign a_sel        = a_raw;
`endif

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (accept)         state_d = EXEC;
            EXEC: if (cnt_q == 4'd0)  state_d = RESP;
            RESP: if (rsp_hs)         state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 2'b00;
        if (accept) begin
            cmd_ready = grant ? 2'b10 : 2'b01;
        end
    end

    always_comb begin
        rsp_valid = 2'b00;
        if (state_q == RESP) begin
            rsp_valid = owner_q ? 2'b10 : 2'b01;
        end
    end

    assign busy   = (state_q != IDLE);
    assign alu_op = op_q;
    assign alu_a  = a_q;
    assign alu_b  = b_q;

    // Operand registers are only rewritten on accept, so the ALU sees them
    // unchanged through EXEC and RESP.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_grant <= 1'b1;
            owner_q    <= 1'b0;
            op_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            cnt_q      <= '0;
            rsp_data   <= '0;
            done_cnt   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q       <= op_sel;
                a_q        <= a_sel;
                b_q        <= b_sel;
                owner_q    <= grant;
                last_grant <= grant;
                cnt_q      <= CNT_INIT;
            end
            if (state_q == EXEC) begin
                if (cnt_q != 4'd0) begin
                    cnt_q <= cnt_q - 4'd1;
                end else begin
                    rsp_data <= alu_f;
                end
            end
            if (rsp_hs) begin
                done_cnt <= done_cnt + CNT_W'(1);
            end
        end
    end

endmodule
